hilo_muldiv_unit: RTL and testbench

HILO_MULDIV_UNIT -- requirements
Module: hilo_muldiv_unit

---
 rtl/hilo_muldiv_unit.sv | 193 +++++++++++++++++++
 tb/tb_hilo_muldiv_unit.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/hilo_muldiv_unit.sv
// HiLo multiply/divide unit: iterative shift-add multiplier (MULTU/MULT/MADD/MSUB)
// plus an optional restoring divider (DIVU/DIV) that is present only when HILO_DIV_EN is defined.
module hilo_muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Start,
    input  logic [2:0]       Op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             HiWe,
    input  logic             LoWe,
    input  logic [WIDTH-1:0] WrData,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo,
    output logic             DivByZero
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [2:0] OP_MULTU = 3'b000;
    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MADD  = 3'b010;
    localparam logic [2:0] OP_MSUB  = 3'b011;
    localparam logic [2:0] OP_DIV   = 3'b101;
`ifdef HILO_DIV_EN
    localparam logic [2:0] OP_DIVU  = 3'b100;

    typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DIV = 2'd2, FIN = 2'd3} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, FIN = 2'd3} state_t;
`endif

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt;
    logic            last_iter;

    // Operand magnitudes; the sign is reapplied to the finished result.
    logic             op_signed, a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;

    logic [2:0]         op_q;
    logic               neg_q;
    logic [2*WIDTH-1:0] hilo_q;
    logic [2*WIDTH-1:0] acc, mcand;
    logic [WIDTH-1:0]   mplier;
    logic [2*WIDTH-1:0] prod, res;
    logic               res_we;

`ifdef HILO_DIV_EN
    logic             rneg_q, dvz_q;
    logic [WIDTH-1:0] a_q, rem, quo, dvsr;
    logic [WIDTH:0]   rem_sh, rem_diff;

    assign rem_sh   = {rem, quo[WIDTH-1]};
    assign rem_diff = rem_sh - {1'b0, dvsr};
`endif

    assign Busy      = (state != IDLE);
    assign last_iter = (cnt == CW'(WIDTH - 1));
    assign op_signed = (Op == OP_MULT) || (Op == OP_MADD) || (Op == OP_MSUB) || (Op == OP_DIV);
    assign a_neg     = op_signed & A[WIDTH-1];
    assign b_neg     = op_signed & B[WIDTH-1];
    assign a_mag     = a_neg ? -A : A;
    assign b_mag     = b_neg ? -B : B;

    // NOTE: sequential state uses <= so every register sees the pre-edge values of its peers.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        // NOTE: assigning a default before the case keeps every path covered, so no latch is inferred.
        state_nxt = state;
        case (state)
            IDLE: begin
                if (Start) begin
                    if (!Op[2])             state_nxt = MUL;
`ifdef HILO_DIV_EN
                    else if (!Op[1])        state_nxt = DIV;
`endif
                    else                    state_nxt = FIN;
                end
            end
            MUL:     if (last_iter) state_nxt = FIN;
`ifdef HILO_DIV_EN
            DIV:     if (last_iter) state_nxt = FIN;
`endif
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: iteration registers carry no reset; they are fully loaded on every accepted Start.
    always_ff @(posedge Clk) begin
        case (state)
            IDLE: begin
                if (Start) begin
                    op_q   <= Op;
                    neg_q  <= a_neg ^ b_neg;
                    hilo_q <= {Hi, Lo};
                    acc    <= '0;
                    mcand  <= {{WIDTH{1'b0}}, a_mag};
                    mplier <= b_mag;
`ifdef HILO_DIV_EN
                    rneg_q <= a_neg;
                    dvz_q  <= (B == '0);
                    a_q    <= A;
                    rem    <= '0;
                    quo    <= a_mag;
                    dvsr   <= b_mag;
`endif
                end
            end
            MUL: begin
                if (mplier[0]) acc <= acc + mcand;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
            end
`ifdef HILO_DIV_EN
            DIV: begin
                if (!rem_diff[WIDTH]) begin
                    rem <= rem_diff[WIDTH-1:0];
                    quo <= {quo[WIDTH-2:0], 1'b1};
                end else begin
                    rem <= rem_sh[WIDTH-1:0];
                    quo <= {quo[WIDTH-2:0], 1'b0};
                end
            end
`endif
            default: ;
        endcase
    end

    always_comb begin
        prod   = neg_q ? -acc : acc;
        res    = {Hi, Lo};
        res_we = 1'b0;
        case (op_q)
            OP_MULTU, OP_MULT: begin res = prod;          res_we = 1'b1; end
            OP_MADD:           begin res = hilo_q + prod; res_we = 1'b1; end
            OP_MSUB:           begin res = hilo_q - prod; res_we = 1'b1; end
`ifdef HILO_DIV_EN
            OP_DIVU, OP_DIV: begin
                res_we = 1'b1;
                if (dvz_q) res = {a_q, {WIDTH{1'b1}}};
                else       res = {rneg_q ? -rem : rem, neg_q ? -quo : quo};
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            cnt  <= '0;
            Done <= 1'b0;
            Hi   <= '0;
            Lo   <= '0;
        end else begin
            Done <= 1'b0;
            cnt  <= (state == IDLE) ? '0 : cnt + CW'(1);
            case (state)
                IDLE: begin
                    // Start wins over a coincident direct write.
                    if (!Start) begin
                        if (HiWe) Hi <= WrData;
                        if (LoWe) Lo <= WrData;
                    end
                end
                FIN: begin
                    Done <= 1'b1;
                    if (res_we) {Hi, Lo} <= res;
                end
                default: ;
            endcase
        end
    end

`ifdef HILO_DIV_EN
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst)                                       DivByZero <= 1'b0;
        else if (state == IDLE && Start)               DivByZero <= 1'b0;
        else if (state == FIN && op_q[2:1] == 2'b10 && dvz_q) DivByZero <= 1'b1;
    end
`else
    assign DivByZero = 1'b0;
`endif

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Directed self-checking bench for hilo_muldiv_unit (WIDTH=32); divide cases
// follow HILO_DIV_EN, otherwise divides are checked as reserved ops.
module tb_hilo_muldiv_unit;
    localparam int W = 32;

    logic         Clk = 1'b0;
    logic         Rst = 1'b0;
    logic         Start, HiWe, LoWe;
    logic [2:0]   Op;
    logic [W-1:0] A, B, WrData;
    logic         Busy, Done, DivByZero;
    logic [W-1:0] Hi, Lo;

    int checks = 0;
    int errors = 0;
    int lat, bsy;

    hilo_muldiv_unit #(.WIDTH(W)) dut (
        .Clk(Clk), .Rst(Rst), .Start(Start), .Op(Op), .A(A), .B(B),
        .HiWe(HiWe), .LoWe(LoWe), .WrData(WrData),
        .Busy(Busy), .Done(Done), .Hi(Hi), .Lo(Lo), .DivByZero(DivByZero)
    );

    always #5 Clk = ~Clk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed no finish expected finish before 100000");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic launch(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge Clk);
        Start = 1'b1; Op = op; A = a; B = b;
        @(posedge Clk); #1;
        Start = 1'b0;
    endtask

    // lat = k when Done is seen k cycles after the accepting edge (1 = cycle right after it); 0 on timeout.
    task automatic wait_done(output int l, output int bc);
        l = 0; bc = 0;
        for (int i = 1; i <= 100 && l == 0; i++) begin
            if (Busy) bc++;
            if (Done) l = i;
            else begin @(posedge Clk); #1; end
        end
    endtask

    task automatic run(input string tag, input logic [2:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] eh, input logic [W-1:0] el,
                       input int elat);
        int l, bc;
        launch(op, a, b);
        wait_done(l, bc);
        chk({tag, "_lat"}, 64'(l), 64'(elat));
        chk({tag, "_hi"}, 64'(Hi), 64'(eh));
        chk({tag, "_lo"}, 64'(Lo), 64'(el));
    endtask

    task automatic wr(input logic hwe, input logic lwe, input logic [W-1:0] d);
        @(negedge Clk);
        HiWe = hwe; LoWe = lwe; WrData = d;
        @(negedge Clk);
        HiWe = 1'b0; LoWe = 1'b0;
    endtask

    initial begin
        Start = 1'b0; Op = 3'b000; A = '0; B = '0; HiWe = 1'b0; LoWe = 1'b0; WrData = '0;

        // Reset takes effect with no clock edge yet.
        #1 Rst = 1'b1;
        #1;
        chk("rst_busy", 64'(Busy), 64'd0);
        chk("rst_done", 64'(Done), 64'd0);
        chk("rst_hi", 64'(Hi), 64'd0);
        chk("rst_lo", 64'(Lo), 64'd0);
        chk("rst_dbz", 64'(DivByZero), 64'd0);
        @(negedge Clk);
        Rst = 1'b0;

        // MULTU max*max: Busy 33 cycles, Done in cycle 34 after acceptance, one cycle wide.
        launch(3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(lat, bsy);
        chk("multu_lat", 64'(lat), 64'd34);
        chk("multu_busy", 64'(bsy), 64'd33);
        chk("multu_hi", 64'(Hi), 64'hFFFF_FFFE);
        chk("multu_lo", 64'(Lo), 64'h0000_0001);
        @(posedge Clk); #1;
        chk("done_pulse", 64'(Done), 64'd0);
        chk("idle_busy", 64'(Busy), 64'd0);

        run("mult_neg", 3'b001, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 34);

        // Accumulate sequence from a directly written Hi:Lo.
        wr(1'b1, 1'b1, 32'd0);
        chk("mthilo_hi", 64'(Hi), 64'd0);
        chk("mthilo_lo", 64'(Lo), 64'd0);
        wr(1'b0, 1'b1, 32'd10);
        chk("mtlo_hi", 64'(Hi), 64'd0);
        chk("mtlo_lo", 64'(Lo), 64'd10);
        run("madd", 3'b010, 32'd2, 32'd3, 32'd0, 32'd16, 34);
        run("msub", 3'b011, 32'd4, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFC, 34);

        // Most-negative operands and an unsigned carry into Hi.
        run("mult_min", 3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, 34);
        run("multu_carry", 3'b000, 32'h8000_0000, 32'd2, 32'd1, 32'd0, 34);

`ifdef HILO_DIV_EN
        run("div_neg", 3'b101, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 34);
        chk("div_neg_dbz", 64'(DivByZero), 64'd0);
        run("divu", 3'b100, 32'd100, 32'd7, 32'd2, 32'd14, 34);
        run("div_negb", 3'b101, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 34);
        run("divu_zero", 3'b100, 32'd7, 32'd0, 32'd7, 32'hFFFF_FFFF, 34);
        chk("dbz_set", 64'(DivByZero), 64'd1);
        @(posedge Clk); #1;
        chk("dbz_sticky", 64'(DivByZero), 64'd1);
        run("div_ovf", 3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 34);
        chk("dbz_clear", 64'(DivByZero), 64'd0);
        run("reserved", 3'b110, 32'd1, 32'd1, 32'd0, 32'h8000_0000, 2);
`else
        run("divu_off", 3'b100, 32'd7, 32'd3, 32'd1, 32'd0, 2);
        run("div0_off", 3'b101, 32'd7, 32'd0, 32'd1, 32'd0, 2);
        chk("dbz_off", 64'(DivByZero), 64'd0);
`endif

        // Start together with a direct write in IDLE: the write is dropped.
        wr(1'b1, 1'b1, 32'h0000_00AA);
        @(negedge Clk);
        Start = 1'b1; Op = 3'b111; HiWe = 1'b1; LoWe = 1'b1; WrData = 32'h0000_0055;
        @(posedge Clk); #1;
        Start = 1'b0; HiWe = 1'b0; LoWe = 1'b0;
        wait_done(lat, bsy);
        chk("startwr_lat", 64'(lat), 64'd2);
        chk("startwr_hi", 64'(Hi), 64'h0000_00AA);
        chk("startwr_lo", 64'(Lo), 64'h0000_00AA);

        // Start and writes while Busy are ignored; no queued second operation.
        launch(3'b000, 32'd3, 32'd5);
        @(negedge Clk);
        Start = 1'b1; Op = 3'b000; A = 32'd9; B = 32'd9;
        HiWe = 1'b1; LoWe = 1'b1; WrData = 32'hDEAD_BEEF;
        @(negedge Clk);
        Start = 1'b0; HiWe = 1'b0; LoWe = 1'b0;
        chk("busywr_hi", 64'(Hi), 64'h0000_00AA);
        wait_done(lat, bsy);
        // Sampling began one cycle after the accepting edge, so Done lands at index 33.
        chk("busy_lat", 64'(lat), 64'd33);
        chk("busy_hi", 64'(Hi), 64'd0);
        chk("busy_lo", 64'(Lo), 64'd15);
        @(posedge Clk); #1;
        chk("no_queue_busy", 64'(Busy), 64'd0);

        // Reset ten cycles into a MULT aborts it with no commit.
        wr(1'b1, 1'b0, 32'h1234_5678);
        launch(3'b001, 32'd5, 32'd6);
        repeat (9) @(posedge Clk);
        #3 Rst = 1'b1;
        #1;
        chk("abort_busy", 64'(Busy), 64'd0);
        chk("abort_done", 64'(Done), 64'd0);
        chk("abort_hi", 64'(Hi), 64'd0);
        chk("abort_lo", 64'(Lo), 64'd0);
        for (int i = 0; i < 2; i++) begin
            @(posedge Clk); #1;
            chk("held_done", 64'(Done), 64'd0);
            chk("held_busy", 64'(Busy), 64'd0);
        end
        @(negedge Clk);
        Rst = 1'b0; Start = 1'b1; Op = 3'b000; A = 32'd6; B = 32'd7;
        @(posedge Clk); #1;
        Start = 1'b0;
        chk("post_rst_busy", 64'(Busy), 64'd1);
        wait_done(lat, bsy);
        chk("post_rst_lat", 64'(lat), 64'd34);
        chk("post_rst_hi", 64'(Hi), 64'd0);
        chk("post_rst_lo", 64'(Lo), 64'd42);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
